// File: rtl/center_pp_buf.sv
// Ping-pong centre buffer: two DEPTH-word banks handed between the feature loader and the CONV PE array.
// Optional byte-strobe writes are enabled by defining CENTER_PP_BUF_STRB_EN.
module center_pp_buf #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned log2_DEPTH = 5,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [log2_DEPTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_dat,
`ifdef CENTER_PP_BUF_STRB_EN
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
`endif
  input  logic                    wr_done,
  output logic                    wr_ready,
  input  logic                    rd_en,
  input  logic [log2_DEPTH-1:0]   rd_addr,
  input  logic                    rd_done,
  output logic                    rd_ready,
  output logic                    rd_dat_vld,
  output logic [DATA_WIDTH-1:0]   rd_dat,
  output logic                    wr_bank,
  output logic                    rd_bank,
  output logic                    wr_err,
  output logic                    rd_err
);

  logic [1:0]            full;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  wr_acc;
  logic                  wr_done_acc;
  logic                  rd_acc;
  logic                  rd_done_acc;

  logic [DATA_WIDTH-1:0] mem [2*DEPTH];

  logic [RD_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0] dat_q [RD_LATENCY];

  assign wr_ready    = ~full[wr_ptr];
  assign rd_ready    = full[rd_ptr];
  assign wr_bank     = wr_ptr;
  assign rd_bank     = rd_ptr;

  assign wr_acc      = wr_en   & wr_ready;
  assign wr_done_acc = wr_done & wr_ready;
  assign rd_acc      = rd_en   & rd_ready;
  assign rd_done_acc = rd_done & rd_ready;

  // wr_done and rd_done always target different banks, so both full bits may update together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      wr_err <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      if (wr_done_acc) begin
        full[wr_ptr] <= 1'b1;
        wr_ptr       <= ~wr_ptr;
      end
      if (rd_done_acc) begin
        full[rd_ptr] <= 1'b0;
        rd_ptr       <= ~rd_ptr;
      end
      if ((wr_en | wr_done) & ~wr_ready) wr_err <= 1'b1;
      if ((rd_en | rd_done) & ~rd_ready) rd_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
`ifdef CENTER_PP_BUF_STRB_EN
      for (int unsigned b = 0; b < DATA_WIDTH/8; b++) begin
        if (wr_strb[b]) mem[{wr_ptr, wr_addr}][b*8 +: 8] <= wr_dat[b*8 +: 8];
      end
`else
      mem[{wr_ptr, wr_addr}] <= wr_dat;
`endif
    end
  end

  // Data stages load only behind a valid bit, so the last stage holds its value between results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= rd_acc;
      if (rd_acc) dat_q[0] <= mem[{rd_ptr, rd_addr}];
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign rd_dat_vld = vld_q[RD_LATENCY-1];
  assign rd_dat     = dat_q[RD_LATENCY-1];

endmodule

// File: tb/tb_center_pp_buf.sv
// Directed self-checking bench for center_pp_buf (RD_LATENCY=3); strobe scenario runs when CENTER_PP_BUF_STRB_EN is defined.
module tb_center_pp_buf;

  localparam int unsigned DW  = 256;
  localparam int unsigned AW  = 5;
  localparam int          LAT = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_dat;
  logic [DW/8-1:0] wr_strb;
  logic            wr_done;
  logic            wr_ready;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic            rd_done;
  logic            rd_ready;
  logic            rd_dat_vld;
  logic [DW-1:0]   rd_dat;
  logic            wr_bank;
  logic            rd_bank;
  logic            wr_err;
  logic            rd_err;

  int n_cmp = 0;
  int n_bad = 0;

  center_pp_buf #(
    .DATA_WIDTH (DW),
    .DEPTH      (32),
    .log2_DEPTH (AW),
    .RD_LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_dat     (wr_dat),
`ifdef CENTER_PP_BUF_STRB_EN
    .wr_strb    (wr_strb),
`endif
    .wr_done    (wr_done),
    .wr_ready   (wr_ready),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_done    (rd_done),
    .rd_ready   (rd_ready),
    .rd_dat_vld (rd_dat_vld),
    .rd_dat     (rd_dat),
    .wr_bank    (wr_bank),
    .rd_bank    (rd_bank),
    .wr_err     (wr_err),
    .rd_err     (rd_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_bank(input logic [31:0] base, input int n);
    for (int a = 0; a < n; a++) begin
      wr_en   = 1'b1;
      wr_addr = a[AW-1:0];
      wr_dat  = DW'(base + 32'(a));
      wr_strb = '1;
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic pulse_wr_done();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
  endtask

  task automatic read_stream(input logic [31:0] base, input int n, input logic done_last, input string tag);
    logic [DW-1:0] exp_d;
    logic          exp_v;
    int            j;
    for (int k = 0; k < n + LAT + 1; k++) begin
      rd_en   = (k < n);
      rd_addr = k[AW-1:0];
      rd_done = done_last && (k == n - 1);
      tick();
      j     = k - LAT + 1;
      exp_v = (j >= 0) && (j < n);
      exp_d = DW'(base + 32'(j));
      n_cmp++;
      if (rd_dat_vld !== exp_v) begin
        n_bad++;
        $display("FAIL %s vld k=%0d: got %b want %b", tag, k, rd_dat_vld, exp_v);
      end
      if (exp_v) begin
        n_cmp++;
        if (rd_dat !== exp_d) begin
          n_bad++;
          $display("FAIL %s dat j=%0d: got %h want %h", tag, j, rd_dat[31:0], exp_d[31:0]);
        end
      end
    end
    rd_en   = 1'b0;
    rd_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({wr_ready, rd_ready, rd_dat_vld, wr_bank, rd_bank, wr_err, rd_err} !== 7'b1000000) begin
      n_bad++;
      $display("FAIL reset flags: got %b want 1000000",
               {wr_ready, rd_ready, rd_dat_vld, wr_bank, rd_bank, wr_err, rd_err});
    end
    n_cmp++;
    if (rd_dat !== '0) begin
      n_bad++;
      $display("FAIL reset rd_dat: got %h want 0", rd_dat);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_read();
    fill_bank(32'h100, 32);
    n_cmp++;
    if (rd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fill pre-done rd_ready: got %b want 0", rd_ready);
    end
    pulse_wr_done();
    n_cmp++;
    if ({rd_ready, wr_ready, wr_bank, rd_bank} !== 4'b1110) begin
      n_bad++;
      $display("FAIL fill post-done rd/wr_ready,wr/rd_bank: got %b want 1110",
               {rd_ready, wr_ready, wr_bank, rd_bank});
    end
    read_stream(32'h100, 32, 1'b0, "fill_read");
  endtask

  task automatic test_overlap();
    logic [DW-1:0] exp_d;
    logic          exp_v;
    int            j;
    for (int k = 0; k < 32 + LAT; k++) begin
      wr_en   = (k < 32);
      wr_addr = k[AW-1:0];
      wr_dat  = DW'(32'h200 + 32'(k));
      wr_strb = '1;
      rd_en   = (k < 32);
      rd_addr = k[AW-1:0];
      tick();
      j     = k - LAT + 1;
      exp_v = (j >= 0) && (j < 32);
      exp_d = DW'(32'h100 + 32'(j));
      n_cmp++;
      if ({wr_bank, rd_bank, rd_dat_vld} !== {2'b10, exp_v}) begin
        n_bad++;
        $display("FAIL overlap banks/vld k=%0d: got %b want %b", k, {wr_bank, rd_bank, rd_dat_vld}, {2'b10, exp_v});
      end
      if (exp_v && rd_dat !== exp_d) begin
        n_bad++;
        $display("FAIL overlap dat j=%0d: got %h want %h", j, rd_dat[31:0], exp_d[31:0]);
      end
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    pulse_wr_done();
    n_cmp++;
    if ({wr_ready, wr_bank} !== 2'b00) begin
      n_bad++;
      $display("FAIL overlap both-full wr_ready,wr_bank: got %b want 00", {wr_ready, wr_bank});
    end
  endtask

  task automatic test_both_full();
    wr_en   = 1'b1;
    wr_addr = '0;
    wr_dat  = DW'(32'hDEAD);
    wr_strb = '1;
    wr_done = 1'b1;
    tick();
    wr_en   = 1'b0;
    wr_done = 1'b0;
    n_cmp++;
    if ({wr_err, wr_ready, wr_bank, rd_ready, rd_bank} !== 5'b10010) begin
      n_bad++;
      $display("FAIL both_full flags: got %b want 10010", {wr_err, wr_ready, wr_bank, rd_ready, rd_bank});
    end
    read_stream(32'h100, 32, 1'b1, "both_full_bank0");
    n_cmp++;
    if ({wr_ready, wr_bank, rd_ready, rd_bank} !== 4'b1011) begin
      n_bad++;
      $display("FAIL release bank0 flags: got %b want 1011", {wr_ready, wr_bank, rd_ready, rd_bank});
    end
    read_stream(32'h200, 32, 1'b1, "bank1");
    n_cmp++;
    if ({rd_ready, rd_bank, wr_err, rd_err} !== 4'b0010) begin
      n_bad++;
      $display("FAIL drained flags: got %b want 0010", {rd_ready, rd_bank, wr_err, rd_err});
    end
  endtask

  task automatic test_empty_read();
    rd_en   = 1'b1;
    rd_addr = '0;
    rd_done = 1'b1;
    tick();
    rd_en   = 1'b0;
    rd_done = 1'b0;
    n_cmp++;
    if ({rd_err, rd_bank, rd_ready} !== 3'b100) begin
      n_bad++;
      $display("FAIL empty_read err/bank/ready: got %b want 100", {rd_err, rd_bank, rd_ready});
    end
    for (int k = 0; k < LAT + 1; k++) begin
      n_cmp++;
      if (rd_dat_vld !== 1'b0) begin
        n_bad++;
        $display("FAIL empty_read vld k=%0d: got %b want 0", k, rd_dat_vld);
      end
      tick();
    end
  endtask

  task automatic test_simul_done();
    fill_bank(32'h300, 32);
    pulse_wr_done();
    fill_bank(32'h400, 31);
    // final write lands in bank1 on the same edge that hands it over
    wr_en   = 1'b1;
    wr_addr = 5'd31;
    wr_dat  = DW'(32'h41F);
    wr_strb = '1;
    wr_done = 1'b1;
    rd_done = 1'b1;
    tick();
    wr_en   = 1'b0;
    wr_done = 1'b0;
    rd_done = 1'b0;
    n_cmp++;
    if ({wr_bank, rd_bank, wr_ready, rd_ready} !== 4'b0111) begin
      n_bad++;
      $display("FAIL simul_done flags: got %b want 0111", {wr_bank, rd_bank, wr_ready, rd_ready});
    end
    read_stream(32'h400, 32, 1'b1, "simul_bank1");
    n_cmp++;
    if ({rd_ready, rd_bank, wr_ready, rd_err} !== 4'b0011) begin
      n_bad++;
      $display("FAIL simul_done drained: got %b want 0011", {rd_ready, rd_bank, wr_ready, rd_err});
    end
  endtask

  task automatic test_reset_mid_read();
    fill_bank(32'h500, 32);
    pulse_wr_done();
    for (int k = 0; k < LAT; k++) begin
      rd_en   = 1'b1;
      rd_addr = k[AW-1:0];
      tick();
    end
    n_cmp++;
    if (rd_dat_vld !== 1'b1 || rd_dat !== DW'(32'h500)) begin
      n_bad++;
      $display("FAIL mid_read pre-reset: got vld %b dat %h want 1 500", rd_dat_vld, rd_dat[31:0]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rd_dat_vld, rd_ready, wr_ready, wr_bank, rd_err, wr_err} !== 6'b001000 || rd_dat !== '0) begin
      n_bad++;
      $display("FAIL mid_read async reset: got %b dat %h want 001000 0",
               {rd_dat_vld, rd_ready, wr_ready, wr_bank, rd_err, wr_err}, rd_dat[31:0]);
    end
    rd_en = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 1; k++) begin
      tick();
      n_cmp++;
      if (rd_dat_vld !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_read discarded vld k=%0d: got %b want 0", k, rd_dat_vld);
      end
    end
  endtask

`ifdef CENTER_PP_BUF_STRB_EN
  task automatic test_strobe();
    logic [DW-1:0] exp_d;
    exp_d = {{(DW/8-1){8'hFF}}, 8'h00};
    wr_en   = 1'b1;
    wr_addr = 5'd7;
    wr_dat  = '1;
    wr_strb = '1;
    tick();
    wr_dat  = '0;
    wr_strb = {{(DW/8-1){1'b0}}, 1'b1};
    tick();
    wr_addr = 5'd8;
    wr_dat  = '0;
    wr_strb = '0;
    tick();
    wr_en = 1'b0;
    pulse_wr_done();
    rd_en   = 1'b1;
    rd_addr = 5'd7;
    tick();
    rd_en = 1'b0;
    for (int k = 1; k < LAT; k++) tick();
    n_cmp++;
    if (rd_dat_vld !== 1'b1 || rd_dat !== exp_d) begin
      n_bad++;
      $display("FAIL strobe readback: got vld %b dat %h want 1 %h", rd_dat_vld, rd_dat, exp_d);
    end
  endtask
`endif

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_dat  = '0;
    wr_strb = '1;
    wr_done = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    rd_done = 1'b0;
    test_reset();
    test_fill_read();
    test_overlap();
    test_both_full();
    test_empty_read();
    test_simul_done();
    test_reset_mid_read();
`ifdef CENTER_PP_BUF_STRB_EN
    test_strobe();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
